// File: rtl/display_time_scheduler.sv
// ============================================================================
// display_time_scheduler
// ----------------------------------------------------------------------------
// Drives the shared HH:MM:SS display path of the entry burglar alarm. It:
//   - divides clk down to a 1 Hz tick and keeps a time-of-day counter (tod),
//   - runs the entry-delay countdown and latches the alarm timestamp,
//   - picks the seconds value for the display decoder, blinking it in ALARM.
//
// Ports:
//   clk             system clock
//   reset           asynchronous, active-high reset
//   armed           level, system armed
//   sensor_trip     pulse, entry sensor fired
//   disarm          pulse, valid code entered
//   show_event      pulse, request review of the last alarm timestamp
//   set_valid       pulse, load time of day from set_value
//   set_value       new time of day in seconds
//   display_seconds registered seconds value for the display decoder
//   source_sel      0=time of day, 1=countdown, 2=alarm, 3=review
//   blank           1 = blank the display (alarm blink)
//   alarm_active    1 while in ALARM
//   event_valid     an alarm timestamp has been latched since reset
//   sec_tick        single-cycle 1 Hz pulse
// ============================================================================
module display_time_scheduler #(
    parameter int CLK_FREQ    = 50000000,
    parameter int ENTRY_DELAY = 30,
    parameter int EVENT_HOLD  = 5,
    parameter int DAY_SECONDS = 86400
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        armed,
    input  logic        sensor_trip,
    input  logic        disarm,
    input  logic        show_event,
    input  logic        set_valid,
    input  logic [31:0] set_value,
    output logic [31:0] display_seconds,
    output logic [1:0]  source_sel,
    output logic        blank,
    output logic        alarm_active,
    output logic        event_valid,
    output logic        sec_tick
);

    // State encoding equals the display source code, so source_sel is the
    // state register itself.
    typedef enum logic [1:0] {
        ST_CLOCK  = 2'd0,
        ST_ENTRY  = 2'd1,
        ST_ALARM  = 2'd2,
        ST_REVIEW = 2'd3
    } state_t;

    localparam logic [31:0] PRESC_LAST = 32'(CLK_FREQ - 1);
    localparam logic [31:0] DAY_LIMIT  = 32'(DAY_SECONDS);
    localparam logic [16:0] TOD_LAST   = 17'(DAY_SECONDS - 1);
    localparam logic [15:0] ENTRY_LOAD = 16'(ENTRY_DELAY);
    localparam logic [15:0] HOLD_LOAD  = 16'(EVENT_HOLD);

    state_t      state_q, state_d;
    logic [31:0] presc_q, presc_d;
    logic        sec_tick_q, sec_tick_d;
    logic [16:0] tod_q, tod_d;
    logic [15:0] countdown_q, countdown_d;
    logic [15:0] hold_cnt_q, hold_cnt_d;
    logic [16:0] alarm_ts_q, alarm_ts_d;
    logic        event_valid_q, event_valid_d;
    logic        blank_q, blank_d;
    logic        alarm_active_q, alarm_active_d;
    logic [31:0] display_q, display_d;

    logic        set_ok;
    logic        trip_req;
    logic        enter_alarm;

    // Out-of-range time loads are dropped entirely (prescaler untouched too).
    assign set_ok = set_valid && (set_value < DAY_LIMIT);

    // ---------------- time base and time of day ----------------
    always_comb begin
        presc_d    = presc_q + 32'd1;
        sec_tick_d = 1'b0;
        if (set_ok) begin
            // Loading the time restarts the current second.
            presc_d = 32'd0;
        end else if (presc_q >= PRESC_LAST) begin
            presc_d    = 32'd0;
            sec_tick_d = 1'b1;
        end

        tod_d = tod_q;
        if (set_ok) begin
            tod_d = set_value[16:0];
        end else if (sec_tick_q) begin
            tod_d = (tod_q >= TOD_LAST) ? 17'd0 : tod_q + 17'd1;
        end
    end

    // ---------------- alarm FSM ----------------
    always_comb begin
        state_d       = state_q;
        countdown_d   = countdown_q;
        hold_cnt_d    = hold_cnt_q;
        alarm_ts_d    = alarm_ts_q;
        event_valid_d = event_valid_q;
        trip_req      = 1'b0;
        enter_alarm   = 1'b0;

        case (state_q)
            ST_CLOCK: begin
                if (armed && sensor_trip) begin
                    trip_req = 1'b1;
                end else if (show_event && event_valid_q) begin
                    state_d    = ST_REVIEW;
                    hold_cnt_d = HOLD_LOAD;
                end
            end
            ST_ENTRY: begin
                if (disarm || !armed) begin
                    state_d = ST_CLOCK;
                end else if (sec_tick_q) begin
                    // <= 1 keeps the countdown from ever wrapping below 0.
                    if (countdown_q <= 16'd1) begin
                        enter_alarm = 1'b1;
                        countdown_d = 16'd0;
                    end else begin
                        countdown_d = countdown_q - 16'd1;
                    end
                end
            end
            ST_ALARM: begin
                if (disarm) begin
                    state_d = ST_CLOCK;
                end
            end
            ST_REVIEW: begin
                if (armed && sensor_trip) begin
                    trip_req = 1'b1;
                end else if (sec_tick_q) begin
                    // A hold of 0 expires on the first tick, same as 1.
                    if (hold_cnt_q <= 16'd1) begin
                        state_d = ST_CLOCK;
                    end else begin
                        hold_cnt_d = hold_cnt_q - 16'd1;
                    end
                end
            end
            default: state_d = ST_CLOCK;
        endcase

        if (trip_req) begin
            if (ENTRY_DELAY == 0) begin
                enter_alarm = 1'b1;
            end else begin
                state_d     = ST_ENTRY;
                countdown_d = ENTRY_LOAD;
            end
        end

        // Timestamp is the tod register value before any same-cycle tick/load.
        if (enter_alarm) begin
            state_d       = ST_ALARM;
            alarm_ts_d    = tod_q;
            event_valid_d = 1'b1;
        end
    end

    // ---------------- registered display outputs ----------------
    // Outputs are computed from next-state values so they show the new
    // state exactly one cycle after the triggering input or tick.
    always_comb begin
        blank_d = 1'b0;
        if (state_d == ST_ALARM && state_q == ST_ALARM) begin
            blank_d = sec_tick_q ? ~blank_q : blank_q;
        end

        alarm_active_d = (state_d == ST_ALARM);

        case (state_d)
            ST_CLOCK: display_d = {15'd0, tod_d};
            ST_ENTRY: display_d = {16'd0, countdown_d};
            default:  display_d = {15'd0, alarm_ts_d};
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_CLOCK;
            presc_q        <= 32'd0;
            sec_tick_q     <= 1'b0;
            tod_q          <= 17'd0;
            countdown_q    <= 16'd0;
            hold_cnt_q     <= 16'd0;
            alarm_ts_q     <= 17'd0;
            event_valid_q  <= 1'b0;
            blank_q        <= 1'b0;
            alarm_active_q <= 1'b0;
            display_q      <= 32'd0;
        end else begin
            state_q        <= state_d;
            presc_q        <= presc_d;
            sec_tick_q     <= sec_tick_d;
            tod_q          <= tod_d;
            countdown_q    <= countdown_d;
            hold_cnt_q     <= hold_cnt_d;
            alarm_ts_q     <= alarm_ts_d;
            event_valid_q  <= event_valid_d;
            blank_q        <= blank_d;
            alarm_active_q <= alarm_active_d;
            display_q      <= display_d;
        end
    end

    assign display_seconds = display_q;
    assign source_sel      = state_q;
    assign blank           = blank_q;
    assign alarm_active    = alarm_active_q;
    assign event_valid     = event_valid_q;
    assign sec_tick        = sec_tick_q;

endmodule

// File: tb/tb_display_time_scheduler.sv
// ============================================================================
// tb_display_time_scheduler
// ----------------------------------------------------------------------------
// Directed bench for display_time_scheduler with CLK_FREQ=4, ENTRY_DELAY=3,
// EVENT_HOLD=5. Inputs change 1 ns after a rising edge; outputs are sampled
// at that same point, away from the edge.
// ============================================================================
module tb_display_time_scheduler;

    logic        clk;
    logic        reset;
    logic        armed;
    logic        sensor_trip;
    logic        disarm;
    logic        show_event;
    logic        set_valid;
    logic [31:0] set_value;
    logic [31:0] display_seconds;
    logic [1:0]  source_sel;
    logic        blank;
    logic        alarm_active;
    logic        event_valid;
    logic        sec_tick;

    int n_cmp  = 0;
    int n_fail = 0;

    display_time_scheduler #(
        .CLK_FREQ    (4),
        .ENTRY_DELAY (3),
        .EVENT_HOLD  (5),
        .DAY_SECONDS (86400)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .armed           (armed),
        .sensor_trip     (sensor_trip),
        .disarm          (disarm),
        .show_event      (show_event),
        .set_valid       (set_valid),
        .set_value       (set_value),
        .display_seconds (display_seconds),
        .source_sel      (source_sel),
        .blank           (blank),
        .alarm_active    (alarm_active),
        .event_valid     (event_valid),
        .sec_tick        (sec_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
        $display("check %-16s observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Advance until sec_tick is high (bounded); leaves time just after that edge.
    task automatic wait_tick();
        int n;
        n = 0;
        step();
        n++;
        while (!sec_tick && n < 20) begin
            step();
            n++;
        end
        check("tick_seen", {31'd0, sec_tick}, 32'd1);
    endtask

    // Consume one tick and let its effect reach the registered outputs.
    task automatic tick_settle();
        wait_tick();
        step();
    endtask

    task automatic do_set(input logic [31:0] v);
        set_valid = 1'b1;
        set_value = v;
        step();
        set_valid = 1'b0;
    endtask

    initial begin
        int k;
        reset       = 1'b1;
        armed       = 1'b0;
        sensor_trip = 1'b0;
        disarm      = 1'b0;
        show_event  = 1'b0;
        set_valid   = 1'b0;
        set_value   = 32'd0;

        // Reset state
        #2;
        check("rst_display", display_seconds, 32'd0);
        check("rst_sel", {30'd0, source_sel}, 32'd0);
        check("rst_blank", {31'd0, blank}, 32'd0);
        check("rst_alarm", {31'd0, alarm_active}, 32'd0);
        check("rst_evvalid", {31'd0, event_valid}, 32'd0);
        check("rst_tick", {31'd0, sec_tick}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Time base: tick every 4th cycle, tod reaches 10 after 10 ticks
        wait_tick();
        k = 0;
        step();
        k++;
        while (!sec_tick && k < 20) begin
            step();
            k++;
        end
        check("tick_period", k, 32'd4);
        step();
        for (int i = 0; i < 8; i++) tick_settle();
        check("tod_10", display_seconds, 32'd10);
        check("tod_sel", {30'd0, source_sel}, 32'd0);

        // Time set and day wrap
        do_set(32'd86398);
        check("set_86398", display_seconds, 32'd86398);
        tick_settle();
        check("tod_86399", display_seconds, 32'd86399);
        tick_settle();
        check("tod_wrap0", display_seconds, 32'd0);
        tick_settle();
        check("tod_wrap1", display_seconds, 32'd1);
        do_set(32'd90000);
        check("set_ignored", display_seconds, 32'd1);

        // Entry aborted by disarm coinciding with the last tick
        do_set(32'd50);
        armed       = 1'b1;
        sensor_trip = 1'b1;
        step();
        sensor_trip = 1'b0;
        check("ab_sel_entry", {30'd0, source_sel}, 32'd1);
        check("ab_cd3", display_seconds, 32'd3);
        tick_settle();
        check("ab_cd2", display_seconds, 32'd2);
        tick_settle();
        check("ab_cd1", display_seconds, 32'd1);
        wait_tick();
        disarm = 1'b1;
        step();
        disarm = 1'b0;
        check("ab_sel_clock", {30'd0, source_sel}, 32'd0);
        check("ab_tod", display_seconds, 32'd53);
        check("ab_alarm", {31'd0, alarm_active}, 32'd0);
        check("ab_evvalid", {31'd0, event_valid}, 32'd0);

        // Entry runs out -> alarm with blink, then disarm
        do_set(32'd100);
        sensor_trip = 1'b1;
        step();
        sensor_trip = 1'b0;
        check("en_sel", {30'd0, source_sel}, 32'd1);
        check("en_cd3", display_seconds, 32'd3);
        tick_settle();
        check("en_cd2", display_seconds, 32'd2);
        tick_settle();
        check("en_cd1", display_seconds, 32'd1);
        tick_settle();
        check("al_sel", {30'd0, source_sel}, 32'd2);
        check("al_ts", display_seconds, 32'd102);
        check("al_active", {31'd0, alarm_active}, 32'd1);
        check("al_blank0", {31'd0, blank}, 32'd0);
        check("al_evvalid", {31'd0, event_valid}, 32'd1);
        tick_settle();
        check("al_blank1", {31'd0, blank}, 32'd1);
        tick_settle();
        check("al_blank2", {31'd0, blank}, 32'd0);
        armed = 1'b0;
        step();
        check("al_unarm_stay", {30'd0, source_sel}, 32'd2);
        armed  = 1'b1;
        disarm = 1'b1;
        step();
        disarm = 1'b0;
        check("dis_sel", {30'd0, source_sel}, 32'd0);
        check("dis_blank", {31'd0, blank}, 32'd0);
        check("dis_alarm", {31'd0, alarm_active}, 32'd0);
        check("dis_tod", display_seconds, 32'd105);

        // Review of the last alarm timestamp for 5 ticks
        wait_tick();
        show_event = 1'b1;
        step();
        show_event = 1'b0;
        check("rv_sel", {30'd0, source_sel}, 32'd3);
        check("rv_ts", display_seconds, 32'd102);
        check("rv_blank", {31'd0, blank}, 32'd0);
        for (int i = 0; i < 4; i++) tick_settle();
        check("rv_hold4", {30'd0, source_sel}, 32'd3);
        tick_settle();
        check("rv_expire", {30'd0, source_sel}, 32'd0);

        // Sensor trip during review goes straight to entry
        show_event = 1'b1;
        step();
        show_event = 1'b0;
        check("rv2_sel", {30'd0, source_sel}, 32'd3);
        sensor_trip = 1'b1;
        step();
        sensor_trip = 1'b0;
        check("rv2_entry", {30'd0, source_sel}, 32'd1);
        check("rv2_cd3", display_seconds, 32'd3);
        for (int i = 0; i < 3; i++) tick_settle();
        check("al2_sel", {30'd0, source_sel}, 32'd2);

        // Asynchronous reset mid-alarm
        #2 reset = 1'b1;
        #1;
        check("ar_display", display_seconds, 32'd0);
        check("ar_sel", {30'd0, source_sel}, 32'd0);
        check("ar_alarm", {31'd0, alarm_active}, 32'd0);
        check("ar_evvalid", {31'd0, event_valid}, 32'd0);
        check("ar_blank", {31'd0, blank}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        show_event = 1'b1;
        step();
        show_event = 1'b0;
        check("ar_show_ign", {30'd0, source_sel}, 32'd0);
        check("ar_evvalid2", {31'd0, event_valid}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/display_time_scheduler.md
Name: display_time_scheduler

Overview:
Sequences the shared HH:MM:SS hex display datapath for the entry burglar alarm. Generates the 1 Hz time base and maintains a time-of-day counter. Runs the entry-delay countdown and latches the alarm timestamp. Selects which 32-bit seconds value drives the downstream display decoder, and blinks the display during an alarm.

Parameters:
CLK_FREQ, 50000000, clock cycles per second; prescaler terminal count is CLK_FREQ-1.
ENTRY_DELAY, 30, entry countdown length in seconds; 0 is legal.
EVENT_HOLD, 5, seconds that a review of the last alarm timestamp stays on the display.
DAY_SECONDS, 86400, time-of-day wrap modulus.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
armed  input  1  level; system is armed
sensor_trip  input  1  single-cycle pulse; entry sensor fired
disarm  input  1  single-cycle pulse; valid code entered
show_event  input  1  single-cycle pulse; request review of last alarm timestamp
set_valid  input  1  single-cycle pulse; load time of day
set_value  input  32  new time of day in seconds
display_seconds  output  32  registered seconds value to the display decoder
source_sel  output  2  0=time of day, 1=countdown, 2=alarm, 3=review
blank  output  1  1 = display must be blanked (blink)
alarm_active  output  1  1 while in the ALARM state
event_valid  output  1  an alarm timestamp has been latched since reset
sec_tick  output  1  single-cycle 1 Hz pulse

Behaviour:
- Reset (async, active-high): state CLOCK. Prescaler, tod, countdown, hold_cnt and alarm_ts are 0. All outputs are 0.
- Prescaler: counts 0..CLK_FREQ-1. sec_tick is registered and asserts for the one cycle after the count reaches CLK_FREQ-1; the count wraps to 0.
- tod: increments on sec_tick and wraps DAY_SECONDS-1 -> 0.
- Time set: set_valid with set_value<DAY_SECONDS loads tod and clears the prescaler. This overrides a same-cycle tick. If set_value>=DAY_SECONDS, the request is ignored entirely.
- State CLOCK: source 0.
  - armed & sensor_trip -> ENTRY, with countdown<=ENTRY_DELAY.
  - If ENTRY_DELAY==0, go directly to ALARM instead.
  - Else if show_event & event_valid -> REVIEW, with hold_cnt<=EVENT_HOLD.
  - show_event with event_valid=0 is ignored.
- State ENTRY: source 1.
  - Exit conditions, highest priority first: disarm -> CLOCK; !armed -> CLOCK; then the tick rule.
  - On sec_tick: if countdown==1 -> ALARM with countdown<=0, else countdown-1.
  - sensor_trip in ENTRY does not restart the countdown.
- ALARM entry: alarm_ts<=tod register value in the transition cycle (pre-increment if a tick coincides). event_valid<=1 and stays 1 until reset.
- State ALARM: source 2. alarm_active=1.
  - blank toggles on each sec_tick, starting at 0 on entry.
  - disarm -> CLOCK with blank<=0; this is the only exit.
  - armed deassertion alone does not exit.
- State REVIEW: source 3, no blink.
  - armed & sensor_trip -> ENTRY; this beats hold expiry.
  - On sec_tick: hold_cnt==1 -> CLOCK, else hold_cnt-1.
  - disarm and show_event are ignored.
  - EVENT_HOLD==0 behaves as 1.
- display_seconds mux, by source_sel:
  - 0 -> tod
  - 1 -> countdown (zero-extended)
  - 2 and 3 -> alarm_ts
- Latency: display_seconds, source_sel, blank and alarm_active are all registered. They reflect the new state/value exactly one cycle after the triggering input or tick.
- Widths and arithmetic: countdown and hold_cnt are 16 bits; tod and alarm_ts are 17 bits, zero-extended to 32. There are no negative values; countdown never underflows below 0.
- Simultaneous events: set_valid is independent of the FSM and may coincide with any transition. The FSM uses the pre-load tod for alarm_ts.
- Reset mid-operation: returns immediately to the reset values, including mid-countdown and mid-alarm.

Test Plan:
- CLK_FREQ=4: sec_tick high every 4th cycle. After 10 ticks, display_seconds=10 and source_sel=0.
- Set 86398, run 3 ticks -> display shows 86399, 0, 1 (wrap). Set 90000 -> ignored, tod unchanged.
- armed=1, ENTRY_DELAY=3, sensor_trip at tod=100 -> source_sel=1 showing 3,2,1. On the third tick -> ALARM, display 102, alarm_active=1, blank toggles 0,1,0 per tick. disarm -> source_sel=0, blank=0.
- ENTRY with disarm and sec_tick in the same cycle while countdown=1 -> CLOCK, no alarm, event_valid stays 0.
- After one alarm, show_event -> source_sel=3 for EVENT_HOLD=5 ticks, then 0. sensor_trip (armed) during review -> ENTRY immediately.
- Reset asserted asynchronously in ALARM -> all outputs 0 in the same cycle. show_event afterwards is ignored (event_valid=0).
